cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter_pkg.sv | 37 +++
 rtl/cdb_fifo.sv | 67 ++++++
 rtl/cdb_arbiter.sv | 124 ++++++++++++
 tb/tb_cdb_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared types, constants and grant helper for the CDB arbiter
package cdb_arbiter_pkg;

    localparam int DATA_TYPE_W   = 32;
    localparam int ROB_ID_TYPE_W = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Bus source encoding; the value is driven directly on cdb_src_o
    typedef enum logic {
        SRC_ARITH = 1'b0,
        SRC_LS    = 1'b1
    } cdb_src_e;

    typedef struct packed {
        logic     valid;
        cdb_src_e src;
    } grant_t;

    // Round-robin pick between the two FIFO heads; on a tie the source that
    // did not win last time gets the bus
    function automatic grant_t pick_grant(input logic arith_ne,
                                          input logic ls_ne,
                                          input cdb_src_e last);
        grant_t g;
        g.valid = arith_ne | ls_ne;
        if (arith_ne && ls_ne)
            g.src = (last == SRC_ARITH) ? SRC_LS : SRC_ARITH;
        else if (ls_ne)
            g.src = SRC_LS;
        else
            g.src = SRC_ARITH;
        return g;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - shallow per-producer result FIFO with flush and global stall
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int W     = 36,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is refused even if the head leaves this cycle
    assign empty     = (count == '0);
    assign push_ok   = push && (count != FULL_CNT);
    assign pop_ok    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage write; entries need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (rdy && !flush && push_ok)
            mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (rdy) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push_ok, pop_ok})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing one registered CDB between arith and LS units
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DATA_W   = DATA_TYPE_W,
    parameter int ROB_ID_W = ROB_ID_TYPE_W,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                misbranch_flag,
    input  logic                arith_valid_i,
    input  logic [ROB_ID_W-1:0] arith_rob_id_i,
    input  logic [DATA_W-1:0]   arith_result_i,
    output logic                arith_ready_o,
    input  logic                ls_valid_i,
    input  logic [ROB_ID_W-1:0] ls_rob_id_i,
    input  logic [DATA_W-1:0]   ls_result_i,
    output logic                ls_ready_o,
    output logic                cdb_valid_o,
    output logic [ROB_ID_W-1:0] cdb_rob_id_o,
    output logic [DATA_W-1:0]   cdb_result_o,
    output logic                cdb_src_o
);

    localparam int ENTRY_W = ROB_ID_W + DATA_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]    FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [ROB_ID_W-1:0] ZERO_ROB  = '0;
    localparam logic [DATA_W-1:0]   ZERO_WORD = '0;

    logic [ENTRY_W-1:0] arith_head;
    logic [ENTRY_W-1:0] ls_head;
    logic [CNT_W-1:0]   arith_count;
    logic [CNT_W-1:0]   ls_count;
    logic               arith_empty;
    logic               ls_empty;
    logic               arith_push;
    logic               ls_push;
    logic               arith_pop;
    logic               ls_pop;
    logic               active;
    cdb_src_e           last_grant;
    cdb_src_e           src_q;
    grant_t             grant;
    logic [ENTRY_W-1:0] grant_entry;

    // Ready looks only at the registered count so it never depends on the pop path
    assign arith_ready_o = (arith_count < FULL_CNT);
    assign ls_ready_o    = (ls_count < FULL_CNT);

    // A flush cycle discards both incoming results and any pending pop
    assign active     = rdy && !misbranch_flag;
    assign arith_push = active && arith_valid_i && arith_ready_o;
    assign ls_push    = active && ls_valid_i && ls_ready_o;

    assign grant       = pick_grant(!arith_empty, !ls_empty, last_grant);
    assign arith_pop   = active && grant.valid && (grant.src == SRC_ARITH);
    assign ls_pop      = active && grant.valid && (grant.src == SRC_LS);
    assign grant_entry = (grant.src == SRC_LS) ? ls_head : arith_head;
    assign cdb_src_o   = src_q;

    cdb_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_arith_fifo (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (misbranch_flag),
        .push      (arith_push),
        .push_data ({arith_rob_id_i, arith_result_i}),
        .pop       (arith_pop),
        .head_data (arith_head),
        .count     (arith_count),
        .empty     (arith_empty)
    );

    cdb_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ls_fifo (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (misbranch_flag),
        .push      (ls_push),
        .push_data ({ls_rob_id_i, ls_result_i}),
        .pop       (ls_pop),
        .head_data (ls_head),
        .count     (ls_count),
        .empty     (ls_empty)
    );

    // Broadcast register and round-robin history; last_grant resets to LS so arith wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_o  <= FALSE;
            cdb_rob_id_o <= ZERO_ROB;
            cdb_result_o <= ZERO_WORD;
            src_q        <= SRC_ARITH;
            last_grant   <= SRC_LS;
        end else if (rdy) begin
            if (misbranch_flag) begin
                cdb_valid_o  <= FALSE;
                cdb_rob_id_o <= ZERO_ROB;
                cdb_result_o <= ZERO_WORD;
                last_grant   <= SRC_LS;
            end else if (grant.valid) begin
                cdb_valid_o                  <= TRUE;
                {cdb_rob_id_o, cdb_result_o} <= grant_entry;
                src_q                        <= grant.src;
                last_grant                   <= grant.src;
            end else begin
                cdb_valid_o  <= FALSE;
                cdb_rob_id_o <= ZERO_ROB;
                cdb_result_o <= ZERO_WORD;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        misbranch_flag = 1'b0;
    logic        arith_valid_i = 1'b0;
    logic [3:0]  arith_rob_id_i = '0;
    logic [31:0] arith_result_i = '0;
    logic        arith_ready_o;
    logic        ls_valid_i = 1'b0;
    logic [3:0]  ls_rob_id_i = '0;
    logic [31:0] ls_result_i = '0;
    logic        ls_ready_o;
    logic        cdb_valid_o;
    logic [3:0]  cdb_rob_id_o;
    logic [31:0] cdb_result_o;
    logic        cdb_src_o;

    int tests = 0;
    int fails = 0;

    int          a_q[$];
    int          l_q[$];
    int          bus_id[$];
    int          bus_src[$];
    logic [31:0] bus_res[$];
    bit          ra_tr[$];
    bit          rl_tr[$];

    cdb_arbiter #(.DATA_W(32), .ROB_ID_W(4), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .misbranch_flag (misbranch_flag),
        .arith_valid_i  (arith_valid_i),
        .arith_rob_id_i (arith_rob_id_i),
        .arith_result_i (arith_result_i),
        .arith_ready_o  (arith_ready_o),
        .ls_valid_i     (ls_valid_i),
        .ls_rob_id_i    (ls_rob_id_i),
        .ls_result_i    (ls_result_i),
        .ls_ready_o     (ls_ready_o),
        .cdb_valid_o    (cdb_valid_o),
        .cdb_rob_id_o   (cdb_rob_id_o),
        .cdb_result_o   (cdb_result_o),
        .cdb_src_o      (cdb_src_o)
    );

    always #5 clk = ~clk;

    // ZERO_ROB must never appear as a broadcast tag
    always @(negedge clk) begin
        if (!rst && cdb_valid_o && cdb_rob_id_o == 4'd0) begin
            fails++;
            $display("FAIL zero_rob_tag: got tag %0d with valid, need nonzero", cdb_rob_id_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; misbranch_flag = 1'b0;
        arith_valid_i = 1'b0; ls_valid_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Handshaking producers: each holds its current entry until ready was high before the edge
    task automatic run_streams(input int ncyc);
        int  ai = 0;
        int  li = 0;
        bit  acc_a;
        bit  acc_l;
        bus_id.delete(); bus_src.delete(); bus_res.delete();
        ra_tr.delete(); rl_tr.delete();
        for (int c = 0; c < ncyc; c++) begin
            arith_valid_i = (ai < a_q.size());
            if (arith_valid_i) begin
                arith_rob_id_i = 4'(a_q[ai]);
                arith_result_i = 32'h100 + 32'(a_q[ai]);
            end
            ls_valid_i = (li < l_q.size());
            if (ls_valid_i) begin
                ls_rob_id_i = 4'(l_q[li]);
                ls_result_i = 32'h200 + 32'(l_q[li]);
            end
            ra_tr.push_back(arith_ready_o);
            rl_tr.push_back(ls_ready_o);
            acc_a = arith_valid_i && arith_ready_o;
            acc_l = ls_valid_i && ls_ready_o;
            tick();
            if (acc_a) ai++;
            if (acc_l) li++;
            if (cdb_valid_o) begin
                bus_id.push_back(int'(cdb_rob_id_o));
                bus_src.push_back(int'(cdb_src_o));
                bus_res.push_back(cdb_result_o);
            end
        end
        arith_valid_i = 1'b0;
        ls_valid_i    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b0; misbranch_flag = 1'b1;
        tick(); tick();
        tests++;
        if ({cdb_valid_o, cdb_rob_id_o, cdb_result_o, cdb_src_o} !== 38'd0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b id=%0d res=%h src=%b, need all 0",
                     cdb_valid_o, cdb_rob_id_o, cdb_result_o, cdb_src_o);
        end
        rst = 1'b0; rdy = 1'b1; misbranch_flag = 1'b0;
        tick();
        tests++;
        if ({arith_ready_o, ls_ready_o} !== 2'b11) begin
            fails++;
            $display("FAIL reset_ready: got %b%b, need 11", arith_ready_o, ls_ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (cdb_valid_o !== 1'b0) begin
                fails++;
                $display("FAIL idle_valid: cycle %0d got %b, need 0", i, cdb_valid_o);
            end
        end
    endtask

    task automatic test_single_arith();
        do_reset();
        arith_valid_i = 1'b1; arith_rob_id_i = 4'd3; arith_result_i = 32'h11;
        tick();
        arith_valid_i = 1'b0;
        tests++;
        if (cdb_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL single_edge_n: got valid %b, need 0", cdb_valid_o);
        end
        tick();
        tests++;
        if ({cdb_valid_o, cdb_rob_id_o, cdb_result_o, cdb_src_o} !== {1'b1, 4'd3, 32'h11, 1'b0}) begin
            fails++;
            $display("FAIL single_edge_n1: got v=%b id=%0d res=%h src=%b, need v=1 id=3 res=11 src=0",
                     cdb_valid_o, cdb_rob_id_o, cdb_result_o, cdb_src_o);
        end
        tick();
        tests++;
        if ({cdb_valid_o, cdb_rob_id_o, cdb_result_o} !== 37'd0) begin
            fails++;
            $display("FAIL single_edge_n2: got v=%b id=%0d res=%h, need all 0",
                     cdb_valid_o, cdb_rob_id_o, cdb_result_o);
        end
    endtask

    task automatic test_contention();
        int exp_id[6]  = '{1, 9, 2, 10, 3, 11};
        int exp_src[6] = '{0, 1, 0, 1, 0, 1};
        bit exp_ra[4]  = '{1, 1, 1, 0};
        bit exp_rl[4]  = '{1, 1, 0, 1};
        do_reset();
        a_q = '{1, 2, 3};
        l_q = '{9, 10, 11};
        run_streams(9);
        tests++;
        if (bus_id.size() != 6) begin
            fails++;
            $display("FAIL contention_count: got %0d broadcasts, need 6", bus_id.size());
        end
        for (int i = 0; i < 6 && i < bus_id.size(); i++) begin
            tests++;
            if (bus_id[i] != exp_id[i] || bus_src[i] != exp_src[i] ||
                bus_res[i] !== ((exp_src[i] == 1 ? 32'h200 : 32'h100) + 32'(exp_id[i]))) begin
                fails++;
                $display("FAIL contention_order[%0d]: got id=%0d src=%0d res=%h, need id=%0d src=%0d",
                         i, bus_id[i], bus_src[i], bus_res[i], exp_id[i], exp_src[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (ra_tr[i] != exp_ra[i] || rl_tr[i] != exp_rl[i]) begin
                fails++;
                $display("FAIL contention_ready[%0d]: got a=%b l=%b, need a=%b l=%b",
                         i, ra_tr[i], rl_tr[i], exp_ra[i], exp_rl[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_id[7]  = '{1, 5, 2, 6, 3, 7, 4};
        int exp_src[7] = '{0, 1, 0, 1, 0, 1, 0};
        bit exp_rl[5]  = '{1, 1, 0, 1, 0};
        do_reset();
        a_q = '{1, 2, 3, 4};
        l_q = '{5, 6, 7};
        run_streams(10);
        tests++;
        if (bus_id.size() != 7) begin
            fails++;
            $display("FAIL backpressure_count: got %0d broadcasts, need 7", bus_id.size());
        end
        for (int i = 0; i < 7 && i < bus_id.size(); i++) begin
            tests++;
            if (bus_id[i] != exp_id[i] || bus_src[i] != exp_src[i]) begin
                fails++;
                $display("FAIL backpressure_order[%0d]: got id=%0d src=%0d, need id=%0d src=%0d",
                         i, bus_id[i], bus_src[i], exp_id[i], exp_src[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (rl_tr[i] != exp_rl[i]) begin
                fails++;
                $display("FAIL backpressure_ls_ready[%0d]: got %b, need %b", i, rl_tr[i], exp_rl[i]);
            end
        end
    endtask

    task automatic test_flush();
        int exp_pre[3] = '{1, 5, 2};
        do_reset();
        a_q = '{1, 2, 3, 4};
        l_q = '{5, 6, 7};
        run_streams(4);
        tests++;
        if (bus_id.size() != 3) begin
            fails++;
            $display("FAIL flush_pre_count: got %0d broadcasts, need 3", bus_id.size());
        end
        for (int i = 0; i < 3 && i < bus_id.size(); i++) begin
            tests++;
            if (bus_id[i] != exp_pre[i]) begin
                fails++;
                $display("FAIL flush_pre_order[%0d]: got %0d, need %0d", i, bus_id[i], exp_pre[i]);
            end
        end
        misbranch_flag = 1'b1;
        arith_valid_i = 1'b1; arith_rob_id_i = 4'd14; arith_result_i = 32'h10e;
        ls_valid_i    = 1'b1; ls_rob_id_i    = 4'd15; ls_result_i    = 32'h20f;
        tick();
        misbranch_flag = 1'b0; arith_valid_i = 1'b0; ls_valid_i = 1'b0;
        tests++;
        if ({cdb_valid_o, cdb_rob_id_o, cdb_result_o, arith_ready_o, ls_ready_o} !== {37'd0, 2'b11}) begin
            fails++;
            $display("FAIL flush_state: got v=%b id=%0d res=%h ready=%b%b, need v=0 id=0 res=0 ready=11",
                     cdb_valid_o, cdb_rob_id_o, cdb_result_o, arith_ready_o, ls_ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (cdb_valid_o !== 1'b0) begin
                fails++;
                $display("FAIL flush_drained: cycle %0d got valid with id %0d, need no broadcast",
                         i, cdb_rob_id_o);
            end
        end
        a_q = '{12};
        l_q = '{13};
        run_streams(4);
        tests++;
        if (bus_id.size() != 2 || bus_id[0] != 12 || bus_src[0] != 0 || bus_id[1] != 13) begin
            fails++;
            $display("FAIL flush_tie_arith_first: got %0d entries first id %0d, need 2 entries 12 then 13",
                     bus_id.size(), bus_id.size() > 0 ? bus_id[0] : -1);
        end
    endtask

    task automatic test_rdy_stall();
        do_reset();
        arith_valid_i = 1'b1; arith_rob_id_i = 4'd4; arith_result_i = 32'h104;
        ls_valid_i    = 1'b1; ls_rob_id_i    = 4'd5; ls_result_i    = 32'h205;
        tick();
        arith_rob_id_i = 4'd6; arith_result_i = 32'h106;
        ls_valid_i = 1'b0;
        tick();
        tests++;
        if ({cdb_valid_o, cdb_rob_id_o, cdb_src_o} !== {1'b1, 4'd4, 1'b0}) begin
            fails++;
            $display("FAIL stall_setup: got v=%b id=%0d, need v=1 id=4", cdb_valid_o, cdb_rob_id_o);
        end
        rdy = 1'b0;
        arith_rob_id_i = 4'd7; arith_result_i = 32'h107;
        ls_valid_i = 1'b1; ls_rob_id_i = 4'd8; ls_result_i = 32'h208;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({cdb_valid_o, cdb_rob_id_o, cdb_result_o, cdb_src_o, arith_ready_o, ls_ready_o}
                    !== {1'b1, 4'd4, 32'h104, 1'b0, 2'b11}) begin
                fails++;
                $display("FAIL stall_hold[%0d]: got v=%b id=%0d res=%h src=%b ready=%b%b, need v=1 id=4 res=104 src=0 ready=11",
                         i, cdb_valid_o, cdb_rob_id_o, cdb_result_o, cdb_src_o, arith_ready_o, ls_ready_o);
            end
        end
        rdy = 1'b1; arith_valid_i = 1'b0; ls_valid_i = 1'b0;
        tick();
        tests++;
        if ({cdb_valid_o, cdb_rob_id_o, cdb_result_o, cdb_src_o} !== {1'b1, 4'd5, 32'h205, 1'b1}) begin
            fails++;
            $display("FAIL stall_resume_1: got v=%b id=%0d src=%b, need v=1 id=5 src=1",
                     cdb_valid_o, cdb_rob_id_o, cdb_src_o);
        end
        tick();
        tests++;
        if ({cdb_valid_o, cdb_rob_id_o, cdb_result_o, cdb_src_o} !== {1'b1, 4'd6, 32'h106, 1'b0}) begin
            fails++;
            $display("FAIL stall_resume_2: got v=%b id=%0d src=%b, need v=1 id=6 src=0",
                     cdb_valid_o, cdb_rob_id_o, cdb_src_o);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (cdb_valid_o !== 1'b0) begin
                fails++;
                $display("FAIL stall_no_extra[%0d]: got valid id %0d, need none", i, cdb_rob_id_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_arith();
        test_contention();
        test_backpressure();
        test_flush();
        test_rdy_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
